// File: rtl/adc_axis_src_pkg.sv
// adc_axis_src_pkg: shared constants for the ADC stream playback source (ramp option: ADC_AXIS_SRC_RAMP_EN)
package adc_axis_src_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_RUN   = 2'd1;
    localparam state_t ST_DRAIN = 2'd2;

    localparam int FIFO_DEPTH  = 2;
    localparam int RD_LATENCY  = 1;
    localparam int RAMP_LANE_W = 16;

endpackage

// File: rtl/adc_axis_src_fifo.sv
// axis_skid_fifo2: two-entry stream buffer whose flush keeps only the head beat already on the bus
module axis_skid_fifo2
    import adc_axis_src_pkg::*;
#(
    parameter int W = 129
) (
    input  logic         clk,
    input  logic         aresetn,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_ready,
    input  logic         i_flush,
    output logic         o_valid,
    output logic [W-1:0] o_data,
    output logic [1:0]   o_count,
    output logic [1:0]   o_count_nxt
);

    logic [W-1:0] r_head;
    logic [W-1:0] r_tail;
    logic [1:0]   r_cnt;
    logic         w_pop;
    logic         w_push;
    logic         w_ld_head_in;
    logic         w_ld_head_tail;
    logic         w_ld_tail;

    // Decode handshake and where an incoming beat lands; flush drops everything except an unaccepted head
    always_comb begin
        w_pop          = (r_cnt != 2'd0) && i_ready;
        w_push         = i_push && !i_flush;
        w_ld_head_tail = w_pop && (r_cnt == 2'd2);
        w_ld_head_in   = w_push && ((r_cnt == 2'd0) || ((r_cnt == 2'd1) && w_pop));
        w_ld_tail      = w_push && (((r_cnt == 2'd1) && !w_pop) || ((r_cnt == 2'd2) && w_pop));
        o_count_nxt    = i_flush ? (((r_cnt != 2'd0) && !w_pop) ? 2'd1 : 2'd0)
                                 : r_cnt + {1'b0, w_push} - {1'b0, w_pop};
        o_valid        = r_cnt != 2'd0;
        o_data         = r_head;
        o_count        = r_cnt;
    end

    // Storage registers; the head only changes when it is empty or accepted, so it is stable under stall
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_head <= '0;
            r_tail <= '0;
            r_cnt  <= 2'd0;
        end else begin
            r_cnt <= o_count_nxt;
            if (w_ld_head_in) r_head <= i_data;
            else if (w_ld_head_tail) r_head <= r_tail;
            if (w_ld_tail) r_tail <= i_data;
        end
    end

endmodule

// File: rtl/adc_axis_src.sv
// adc_axis_src: AXI4-stream master replaying ADC beats from a playback BRAM (ramp option: ADC_AXIS_SRC_RAMP_EN)
module adc_axis_src
    import adc_axis_src_pkg::*;
#(
    parameter int DATAWIDTH = 128,
    parameter int ADDRWIDTH = 13,
    parameter int CNTWIDTH  = 32
) (
    input  logic                 clk,
    input  logic                 aresetn,
`ifdef ADC_AXIS_SRC_RAMP_EN
    input  logic                 ramp_sel,
`endif
    input  logic                 start,
    input  logic                 stop,
    input  logic                 loop_en,
    input  logic [ADDRWIDTH-1:0] length,
    output logic                 mem_en,
    output logic [ADDRWIDTH-1:0] mem_addr,
    input  logic [DATAWIDTH-1:0] mem_rdata,
    output logic [DATAWIDTH-1:0] m_tdata,
    output logic                 m_tvalid,
    output logic                 m_tlast,
    input  logic                 m_tready,
    output logic                 busy,
    output logic                 done,
    output logic [CNTWIDTH-1:0]  beat_count
);

    localparam int                   LANES    = DATAWIDTH / RAMP_LANE_W;
    localparam logic [ADDRWIDTH-1:0] ADDR_ONE = ADDRWIDTH'(1);

    state_t                r_state;
    logic [ADDRWIDTH-1:0]  r_len;
    logic [ADDRWIDTH-1:0]  r_rd_addr;
    logic                  r_inflight;
    logic                  r_inflight_last;
    logic                  r_abort;
    logic                  r_done;
    logic [CNTWIDTH-1:0]   r_beat_count;
    logic                  w_start;
    logic                  w_issue;
    logic                  w_pop;
    logic                  w_flush;
    logic                  w_push;
    logic                  w_last_addr;
    logic                  w_fifo_valid;
    logic [1:0]            w_count;
    logic [1:0]            w_count_nxt;
    logic [DATAWIDTH-1:0]  w_beat_data;
    logic [DATAWIDTH:0]    w_head;

`ifdef ADC_AXIS_SRC_RAMP_EN
    logic                  r_ramp_sel;
    logic [15:0]           r_ramp_base;
    logic [15:0]           r_inflight_base;
    logic [DATAWIDTH-1:0]  w_ramp;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign w_ramp[k*RAMP_LANE_W +: RAMP_LANE_W] = r_inflight_base + 16'(k);
    end

    // Ramp beat numbering runs from start across passes; the base is tagged with the read it belongs to
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_ramp_sel      <= 1'b0;
            r_ramp_base     <= '0;
            r_inflight_base <= '0;
        end else if (w_start) begin
            r_ramp_sel  <= ramp_sel;
            r_ramp_base <= '0;
        end else if (w_issue) begin
            r_ramp_base     <= r_ramp_base + 16'(LANES);
            r_inflight_base <= r_ramp_base;
        end
    end

    // Ramp replaces BRAM data while the read itself still runs, keeping timing unchanged
    always_comb w_beat_data = r_ramp_sel ? w_ramp : mem_rdata;
`else
    // Beat payload comes straight from the BRAM read port
    always_comb w_beat_data = mem_rdata;
`endif

    // Read issue keeps buffered plus in-flight beats within the FIFO depth after this cycle's pop
    always_comb begin
        w_pop       = w_fifo_valid && m_tready;
        w_start     = (r_state == ST_IDLE) && start && !stop && (length != '0);
        w_flush     = (r_state == ST_RUN) && stop;
        w_push      = r_inflight && !r_abort;
        w_last_addr = r_rd_addr == (r_len - ADDR_ONE);
        w_issue     = (r_state == ST_RUN)
                    && (({1'b0, w_count} + {2'b0, r_inflight}) < (3'(FIFO_DEPTH) + {2'b0, w_pop}));
        mem_en      = w_issue;
        mem_addr    = r_rd_addr;
        m_tvalid    = w_fifo_valid;
        m_tlast     = w_head[DATAWIDTH];
        m_tdata     = w_head[DATAWIDTH-1:0];
        busy        = r_state != ST_IDLE;
        done        = r_done;
        beat_count  = r_beat_count;
    end

    // Playback sequencer: start latches the pass, stop aborts into DRAIN, DRAIN exits once nothing remains
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_state         <= ST_IDLE;
            r_len           <= '0;
            r_rd_addr       <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_abort         <= 1'b0;
            r_done          <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_inflight <= w_issue;
            if (w_issue) r_inflight_last <= w_last_addr;
            if (w_start) begin
                r_state   <= ST_RUN;
                r_len     <= length;
                r_rd_addr <= '0;
                r_abort   <= 1'b0;
            end else if (w_flush) begin
                r_state <= ST_DRAIN;
                r_abort <= 1'b1;
            end else if (w_issue) begin
                if (!w_last_addr) r_rd_addr <= r_rd_addr + ADDR_ONE;
                else if (loop_en) r_rd_addr <= '0;
                else r_state <= ST_DRAIN;
            end else if ((r_state == ST_DRAIN) && (w_count_nxt == 2'd0)) begin
                r_state <= ST_IDLE;
                r_done  <= 1'b1;
                r_abort <= 1'b0;
            end
        end
    end

    // Accepted-beat counter, cleared by each accepted start and free-running modulo its width
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) r_beat_count <= '0;
        else if (w_start) r_beat_count <= '0;
        else if (w_pop) r_beat_count <= r_beat_count + CNTWIDTH'(1);
    end

    axis_skid_fifo2 #(.W(DATAWIDTH + 1)) u_fifo (
        .clk         (clk),
        .aresetn     (aresetn),
        .i_push      (w_push),
        .i_data      ({r_inflight_last, w_beat_data}),
        .i_ready     (m_tready),
        .i_flush     (w_flush),
        .o_valid     (w_fifo_valid),
        .o_data      (w_head),
        .o_count     (w_count),
        .o_count_nxt (w_count_nxt)
    );

endmodule

// File: tb/tb_adc_axis_src.sv
// tb_adc_axis_src: randomized scoreboard bench for the ADC stream playback source
module tb_adc_axis_src;

    localparam int DW = 128;
    localparam int AW = 13;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          aresetn = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          loop_en = 1'b0;
    logic          m_tready = 1'b0;
    logic [AW-1:0] length = '0;
    logic          mem_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tlast;
    logic          busy;
    logic          done;
    logic [CW-1:0] beat_count;
`ifdef ADC_AXIS_SRC_RAMP_EN
    logic          ramp_sel = 1'b0;
`endif

    logic [DW-1:0] bram [64];
    logic [DW:0]   exp_q [$];
    int            checks = 0;
    int            failures = 0;
    int            cyc = 0;
    int            hs = 0;
    int            last_hs_cyc = 0;
    int            done_cnt = 0;
    int            ready_mode = 0;
    int            cur_len = 0;
    logic          prev_stall = 1'b0;
    logic [DW:0]   prev_beat = '0;

    always #5 clk = ~clk;

    adc_axis_src #(.DATAWIDTH(DW), .ADDRWIDTH(AW), .CNTWIDTH(CW)) dut (
        .clk        (clk),
        .aresetn    (aresetn),
`ifdef ADC_AXIS_SRC_RAMP_EN
        .ramp_sel   (ramp_sel),
`endif
        .start      (start),
        .stop       (stop),
        .loop_en    (loop_en),
        .length     (length),
        .mem_en     (mem_en),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .m_tdata    (m_tdata),
        .m_tvalid   (m_tvalid),
        .m_tlast    (m_tlast),
        .m_tready   (m_tready),
        .busy       (busy),
        .done       (done),
        .beat_count (beat_count)
    );

    task automatic chk(string name, logic [DW:0] act, logic [DW:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW:0] expect_beat(int i, int len, bit ramp);
        logic [DW-1:0] d;
        int a;
        a = i % len;
        d = bram[a];
        if (ramp) for (int k = 0; k < DW / 16; k++) d[k*16 +: 16] = 16'(i * (DW / 16) + k);
        return {a == len - 1, d};
    endfunction

    always @(posedge clk) cyc++;

    always @(posedge clk)
        mem_rdata <= mem_en ? bram[mem_addr[5:0]] : {$urandom, $urandom, $urandom, $urandom};

    initial forever begin
        @(posedge clk);
        #1;
        m_tready = (ready_mode == 0) || ($urandom_range(0, 1) == 1);
    end

    always @(negedge clk) begin
        if (!aresetn) prev_stall = 1'b0;
        else begin
            if (prev_stall) begin
                chk("stall_valid", m_tvalid, 1);
                chk("stall_beat", {m_tlast, m_tdata}, prev_beat);
            end
            if (m_tvalid && m_tready) begin
                hs++;
                last_hs_cyc = cyc;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat actual=%h required=none", {m_tlast, m_tdata});
                end else chk("beat", {m_tlast, m_tdata}, exp_q.pop_front());
            end
            if (mem_en) chk("addr_in_pass", (int'(mem_addr) < cur_len), 1);
            if (done) done_cnt++;
            prev_stall = m_tvalid && !m_tready;
            prev_beat  = {m_tlast, m_tdata};
        end
    end

    task automatic run(int len, bit lp, int n, bit ramp, bit poke);
        int  base_done;
        int  c;
        logic v1;
        cur_len = len;
        for (int i = 0; i < n; i++) exp_q.push_back(expect_beat(i, len, ramp));
        base_done = done_cnt;
        hs = 0;
        length = AW'(len);
        loop_en = lp;
`ifdef ADC_AXIS_SRC_RAMP_EN
        ramp_sel = ramp;
`endif
        start = 1'b1;
        tick();
        start = 1'b0;
        length = AW'($urandom_range(0, 40));
`ifdef ADC_AXIS_SRC_RAMP_EN
        ramp_sel = ~ramp;
`endif
        chk("start_T", {busy, mem_en, m_tvalid}, 3'b110);
        tick();
        v1 = m_tvalid;
        tick();
        chk("latency", {v1, m_tvalid}, 2'b01);
        if (poke) begin
            length = AW'(2);
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        if (lp) begin
            c = 0;
            while (!(hs == n - 1 && m_tvalid) && c < 1000) begin
                tick();
                c++;
            end
            chk("stop_point_reached", (c < 1000), 1);
            stop = 1'b1;
            tick();
            stop = 1'b0;
        end
        c = 0;
        while (!done && c < 1000) begin
            tick();
            c++;
        end
        chk("done_seen", (c < 1000), 1);
        if (!lp) chk("done_timing", cyc, last_hs_cyc + 1);
        chk("beat_count", beat_count, n);
        tick();
        chk("idle_after", {busy, done}, 2'b00);
        chk("done_once", done_cnt - base_done, 1);
        chk("queue_empty", exp_q.size(), 0);
        chk("hs_total", hs, n);
    endtask

    initial begin
        int base;
        int c;
        int len;
        bit lp;
        for (int i = 0; i < 64; i++) bram[i] = DW'(i);
        #1;
        chk("reset_state", {m_tvalid, m_tlast, mem_en, busy, done, |m_tdata, |mem_addr, |beat_count}, 0);
        tick();
        tick();
        aresetn = 1'b1;
        tick();

        ready_mode = 0;
        run(4, 0, 4, 0, 0);
        ready_mode = 1;
        run(4, 0, 4, 0, 1);
        ready_mode = 0;
        run(3, 1, 10, 0, 0);
        run(1, 1, 5, 0, 0);

        base = done_cnt;
        cur_len = 0;
        length = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        chk("len0_ignored", {busy, mem_en, m_tvalid}, 0);
        length = AW'(5);
        start = 1'b1;
        stop = 1'b1;
        tick();
        start = 1'b0;
        stop = 1'b0;
        repeat (4) tick();
        chk("stop_beats_start", {busy, mem_en, m_tvalid}, 0);
        chk("no_done_idle", done_cnt - base, 0);

        ready_mode = 1;
        cur_len = 8;
        for (int i = 0; i < 8; i++) exp_q.push_back(expect_beat(i, 8, 0));
        hs = 0;
        length = AW'(8);
        loop_en = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        c = 0;
        while (hs < 2 && c < 200) begin
            tick();
            c++;
        end
        #2 aresetn = 1'b0;
        #1;
        chk("reset_mid_run", {m_tvalid, m_tlast, mem_en, busy, done, |m_tdata, |mem_addr, |beat_count}, 0);
        exp_q.delete();
        tick();
        tick();
        aresetn = 1'b1;
        tick();
        run(4, 0, 4, 0, 0);

        for (int i = 0; i < 64; i++) bram[i] = {$urandom, $urandom, $urandom, $urandom};
        repeat (8) begin
            ready_mode = $urandom_range(0, 1);
            len = $urandom_range(1, 12);
            lp = 1'($urandom_range(0, 1));
            run(len, lp, lp ? $urandom_range(3, 30) : len, 0, !lp && len >= 4);
        end

`ifdef ADC_AXIS_SRC_RAMP_EN
        ready_mode = 0;
        run(2, 1, 3, 1, 0);
        ready_mode = 1;
        run(3, 1, 11, 1, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout actual=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

endmodule
